// File: rtl/dyna_pkg.sv
// Shared constants, FSM state type and checksum helper for the Dynamixel
// Protocol 1.0 exerciser.
package dyna_pkg;

  localparam logic [7:0] HDR         = 8'hFF;
  localparam logic [7:0] INST_WRITE  = 8'h03;
  localparam logic [7:0] ADDR_GOAL   = 8'h1E;
  localparam logic [7:0] ADDR_TORQUE = 8'h18;
  localparam logic [7:0] LEN_GOAL    = 8'h05;
  localparam logic [7:0] LEN_TORQUE  = 8'h04;
  localparam logic [7:0] TORQUE_ON   = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } dyna_state_t;

  // Inverted 8-bit sum over ID, LENGTH, INSTRUCTION and parameters.
  function automatic logic [7:0] dyna_checksum(
    input logic [7:0] id,
    input logic [7:0] len,
    input logic [7:0] addr,
    input logic [7:0] p0,
    input logic [7:0] p1
  );
    logic [7:0] sum;
    sum = id + len + INST_WRITE + addr + p0 + p1;
    return ~sum;
  endfunction

endpackage

// File: rtl/dyna_uart_tx.sv
// 8N1 transmitter, LSB first, BAUD_DIV clocks per bit. ready rises in the
// last stop-bit cycle so a waiting byte follows with no idle gap.
module dyna_uart_tx #(
  parameter int BAUD_DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_busy;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_ready   = !r_busy || (w_bit_end && (r_bit == 4'd9));
  assign o_tx      = r_tx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
    end else if (i_valid && o_ready) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= {1'b1, i_data};
      r_bit   <= '0;
      r_baud  <= '0;
    end else if (r_busy) begin
      if (!w_bit_end) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        r_baud <= '0;
        // r_bit counts the bit currently on the line; 9 is the stop bit.
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[8:1]};
          r_bit   <= r_bit + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dyna_test.sv
// Dynamixel goal-position exerciser: periodic WRITE_DATA packets over 8N1.
// Define DYNA_TORQUE_EN to send a torque-enable packet first after each reset.
module dyna_test
  import dyna_pkg::*;
#(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          BAUD_DIV = 50,
  parameter int          GAP      = 1000,
  parameter logic [15:0] POS_A    = 16'h0000,
  parameter logic [15:0] POS_B    = 16'h03FF
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [7:0] LED
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
`ifdef DYNA_TORQUE_EN
  localparam logic TQ_AT_RESET = 1'b1;
`else
  localparam logic TQ_AT_RESET = 1'b0;
`endif

  logic          w_rst;
  dyna_state_t   r_state, w_state_next;
  logic [GW-1:0] r_gap;
  logic [3:0]    r_idx, w_idx, w_len;
  logic [7:0]    r_id;
  logic [15:0]   r_pos;
  logic          r_pos_sel;
  logic [4:0]    r_count;
  logic          r_tq, r_tq_pending;
  logic          w_start, w_valid, w_done, w_ready, w_tx;
  logic [7:0]    w_byte;

  assign w_rst = ~KEY[0];
  assign w_len = r_tq ? 4'd8 : 4'd9;
  // Byte 0 goes out on the same edge that leaves IDLE, so the mux sees index 0 there.
  assign w_idx = (r_state == ST_IDLE) ? 4'd0 : r_idx;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_valid      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_gap == GAP_LAST && KEY[1]) begin
          w_start      = 1'b1;
          w_valid      = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_idx != w_len) begin
          w_valid = 1'b1;
        end else if (w_ready) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte = HDR;
    if (r_tq) begin
      case (w_idx)
        4'd2:    w_byte = r_id;
        4'd3:    w_byte = LEN_TORQUE;
        4'd4:    w_byte = INST_WRITE;
        4'd5:    w_byte = ADDR_TORQUE;
        4'd6:    w_byte = TORQUE_ON;
        4'd7:    w_byte = dyna_checksum(r_id, LEN_TORQUE, ADDR_TORQUE, TORQUE_ON, 8'h00);
        default: w_byte = HDR;
      endcase
    end else begin
      case (w_idx)
        4'd2:    w_byte = r_id;
        4'd3:    w_byte = LEN_GOAL;
        4'd4:    w_byte = INST_WRITE;
        4'd5:    w_byte = ADDR_GOAL;
        4'd6:    w_byte = r_pos[7:0];
        4'd7:    w_byte = r_pos[15:8];
        4'd8:    w_byte = dyna_checksum(r_id, LEN_GOAL, ADDR_GOAL, r_pos[7:0], r_pos[15:8]);
        default: w_byte = HDR;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= ST_IDLE;
      r_gap        <= '0;
      r_idx        <= '0;
      r_id         <= '0;
      r_pos        <= '0;
      r_pos_sel    <= 1'b0;
      r_count      <= '0;
      r_tq         <= 1'b0;
      r_tq_pending <= TQ_AT_RESET;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && r_gap != GAP_LAST)
        r_gap <= r_gap + 1'b1;
      if (w_start) begin
        r_id         <= {4'b0000, SW};
        r_pos        <= r_pos_sel ? POS_B : POS_A;
        r_tq         <= r_tq_pending;
        r_tq_pending <= 1'b0;
        r_idx        <= 4'd1;
        r_gap        <= '0;
      end else if (w_valid && w_ready) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_done && !r_tq) begin
        r_pos_sel <= ~r_pos_sel;
        r_count   <= r_count + 1'b1;
      end
    end
  end

  dyna_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .i_clk  (CLOCK_50),
    .i_rst  (w_rst),
    .i_data (w_byte),
    .i_valid(w_valid),
    .o_ready(w_ready),
    .o_tx   (w_tx)
  );

  assign LED = {r_count, r_pos_sel, (r_state == ST_SEND), w_tx};

endmodule

// File: tb/tb_dyna_test.sv
// Directed bench for dyna_test: decodes the serial line on LED[0] and compares
// packets, timing and LED status against hand-computed tables.
module tb_dyna_test;

  localparam int BD  = 50;
  localparam int GAP = 1000;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;

  dyna_test #(.BAUD_DIV(BD), .GAP(GAP)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .LED     (led)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int busy_run = 0;
  int last_busy = 0;

  // Length of the most recent completed LED[1] high run, in cycles.
  always @(negedge clk) begin
    if (led[1] === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  typedef struct {
    logic [3:0]  sw;
    logic [3:0]  sw_mid;
    bit          pause_mid;
    logic [71:0] bytes;
    bit          sel;
    int          cnt;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic rx_byte(input int max_wait, output logic [7:0] b, output int waited,
                         output bit ok, output bit frame_ok);
    logic [9:0] bits;
    waited = 0; ok = 1'b1; frame_ok = 1'b1; b = '0; bits = '0;
    while (led[0] !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (led[0] !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BD; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[i] = led[0];
        else if (led[0] !== bits[i]) frame_ok = 1'b0;
      end
    end
    @(negedge clk);
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_ok = 1'b0;
    b = bits[8:1];
  endtask

  task automatic rx_packet(input string tag, input int first_wait, input int nbytes,
                           input logic [71:0] exp, input logic [3:0] sw_mid,
                           input bit pause_mid, output int waited0);
    logic [7:0] b;
    int w;
    bit ok, fo;
    waited0 = -1;
    for (int k = 0; k < nbytes; k++) begin
      rx_byte((k == 0) ? first_wait : 0, b, w, ok, fo);
      if (k == 0) waited0 = w;
      if (!ok) begin
        check($sformatf("%s byte%0d start bit timeout", tag, k), 0, 1);
        return;
      end
      check($sformatf("%s byte%0d", tag, k), int'(b), int'(exp[71-8*k -: 8]));
      check($sformatf("%s byte%0d framing", tag, k), int'(fo), 1);
      if (k == 0) begin
        sw = sw_mid;
        if (pause_mid) key[1] = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   w;
    int   exp_wait;
    int   seen;

    tbl[0] = '{4'd1, 4'd1, 1'b0, 72'hFFFF0105031E0000D8, 1'b1, 1};
    tbl[1] = '{4'd1, 4'd1, 1'b0, 72'hFFFF0105031EFF03D6, 1'b0, 2};
    tbl[2] = '{4'd5, 4'hF, 1'b0, 72'hFFFF0505031E0000D4, 1'b1, 3};
    tbl[3] = '{4'd1, 4'd1, 1'b1, 72'hFFFF0105031EFF03D6, 1'b0, 4};
    tbl[4] = '{4'd2, 4'd2, 1'b0, 72'hFFFF0205031E0000D7, 1'b1, 5};

    key = 2'b10;
    sw  = 4'd1;
    repeat (5) @(negedge clk);
    check("reset LED", int'(led), 8'h01);
    key[0] = 1'b1;

`ifdef DYNA_TORQUE_EN
    rx_packet("torque", GAP + 5, 8, {64'hFFFF0104031801DE, 8'h00}, 4'd1, 1'b0, w);
    #1;
    check("torque first start latency", w, GAP);
    check("torque busy length", last_busy, 8 * 10 * BD);
    check("torque LED[7:2]", int'(led[7:2]), 0);
`endif

    for (int i = 0; i < 5; i++) begin
      exp_wait = GAP;
      sw = tbl[i].sw;
      if (key[1] == 1'b0) begin
        seen = 0;
        for (int c = 0; c < GAP + 300; c++) begin
          @(negedge clk);
          if (led[0] !== 1'b1 || led[1] !== 1'b0) seen++;
        end
        check("pause holds line idle", seen, 0);
        key[1] = 1'b1;
        exp_wait = 1;
      end
      rx_packet($sformatf("pkt%0d", i), GAP + 5, 9, tbl[i].bytes, tbl[i].sw_mid,
                tbl[i].pause_mid, w);
      #1;
      check($sformatf("pkt%0d start wait", i), w, exp_wait);
      check($sformatf("pkt%0d busy length", i), last_busy, 9 * 10 * BD);
      check($sformatf("pkt%0d LED[2]", i), int'(led[2]), int'(tbl[i].sel));
      check($sformatf("pkt%0d LED[7:3]", i), int'(led[7:3]), tbl[i].cnt);
      check($sformatf("pkt%0d LED[1] idle", i), int'(led[1]), 0);
    end

    // Reset in the middle of the next start bit.
    sw = 4'd1;
    w = 0;
    while (led[0] !== 1'b0 && w < GAP + 5) begin
      @(negedge clk);
      w++;
    end
    check("pkt5 start wait", w, GAP);
    repeat (20) @(negedge clk);
    key[0] = 1'b0;
    #1;
    check("async reset LED", int'(led), 8'h01);
    repeat (3) @(negedge clk);
    key[0] = 1'b1;

`ifdef DYNA_TORQUE_EN
    rx_packet("torque after reset", GAP + 5, 8, {64'hFFFF0104031801DE, 8'h00}, 4'd1, 1'b0, w);
    #1;
    check("torque after reset start wait", w, GAP);
`endif
    rx_packet("after reset", GAP + 5, 9, 72'hFFFF0105031E0000D8, 4'd1, 1'b0, w);
    #1;
    check("after reset start wait", w, GAP);
    check("after reset LED[2]", int'(led[2]), 1);
    check("after reset LED[7:3]", int'(led[7:3]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dyna_test.md
Name: dyna_test

Overview:
- Board-level Dynamixel (Protocol 1.0) exerciser for the Minibot FPGA.
- After reset, periodically builds a WRITE_DATA "goal position" packet for the servo ID selected on SW, alternating between two positions.
- Serialises each packet with an internal 8N1 UART and mirrors the serial line plus status on LED for scope/LED observation.
- Top-level block instantiated directly on the DE0-Nano-style pins.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency (documentation/derivation only)
- BAUD_DIV, 50, clock cycles per UART bit (1 Mbaud at 50 MHz)
- GAP, 1000, idle cycles between the end of one packet and the start of the next
- POS_A, 16'h0000, first goal position
- POS_B, 16'h03FF, second goal position

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge
- KEY  in  2  KEY[0]: reset pin; internal reset rst = ~KEY[0]. Reset is asynchronous and active-high. KEY[1]: active-low pause
- SW  in  4  servo ID = {4'b0000, SW}, sampled at packet start
- LED  out  8  LED[0]=TX line, LED[1]=busy, LED[2]=position select, LED[7:3]=packet count

Behaviour:
- Reset (rst=1, asynchronous):
  - LED[0]=1 (line idle high); LED[7:1]=0.
  - FSM to IDLE; gap counter=0; position select=0 (POS_A); packet count=0.
- FSM states and transitions:
  - IDLE: gap counter increments each cycle. When it reaches GAP-1 and KEY[1]=1, latch ID and target, go to SEND, set busy=1.
  - KEY[1]=0 holds the counter at GAP-1; no new packet starts.
  - SEND: transmit the 9 packet bytes in order, then go to IDLE with gap counter=0, busy=0, toggle position select, increment packet count (5-bit wrap 31->0).
  - KEY[1] going low mid-packet does not abort the packet.
- Packet bytes, in order:
  - FF, FF, ID, 05, 03, 1E, POS[7:0], POS[15:8], CHK.
  - CHK = ~(ID+05+03+1E+POS_L+POS_H), truncated to 8 bits.
- UART framing:
  - 8N1, LSB first: start bit 0, 8 data bits, stop bit 1. Each bit lasts exactly BAUD_DIV cycles.
  - Bytes are back-to-back with no inter-byte gap.
  - Packet length = 9*10*BAUD_DIV = 4500 cycles at default.
- First packet:
  - Start bit begins GAP cycles after reset release.
  - Start bit is registered, so LED[0] falls on the cycle after the FSM leaves IDLE (one-cycle latency).
- SW changes mid-packet do not affect the packet in flight.

Optional Feature:
- Macro: DYNA_TORQUE_EN
- Defined:
  - The first packet after every reset is torque-enable: FF FF ID 04 03 18 01 CHK, with CHK = ~(ID+04+03+18+01).
  - Torque-enable does not toggle position select and does not count.
  - Goal-position packets follow after the normal GAP.
- Undefined: the first packet is a goal-position packet.

Decomposition:
- Package dyna_pkg:
  - Constants HDR=8'hFF, INST_WRITE=8'h03, ADDR_GOAL=8'h1E, ADDR_TORQUE=8'h18.
  - FSM state enum.
  - Checksum function.
- Sub-module dyna_uart_tx (BAUD_DIV parameter):
  - Inputs: data[7:0], valid.
  - Outputs: ready, tx.
  - Accepts a byte when valid && ready; ready is re-asserted in the last cycle of the stop bit, so consecutive bytes run back-to-back.
- Top holds the packet FSM, byte ROM/mux and LED mapping.

Test Plan:
- Reset held, then released; KEY[1]=1, SW=0001 -> LED[0]=1 and LED[7:1]=0 during reset; first start bit GAP cycles after release; decoded bytes FF FF 01 05 03 1E 00 00 D8.
- Second packet, same setup -> bytes FF FF 01 05 03 1E FF 03 D6; LED[2]=1 during and after the first packet's completion; LED[7:3]=1 after the first packet.
- Bit timing -> every bit exactly 50 cycles, start bit 0, stop bit 1, LED[1]=1 for exactly 4500 cycles per packet.
- Pause: KEY[1]=0 mid-packet -> current packet completes; no further start bit while KEY[1]=0; the next packet starts within 1 cycle of KEY[1] returning to 1.
- Reset asserted mid-byte -> LED[0] goes to 1 immediately (asynchronous); FSM restarts; the next packet uses POS_A.
- With DYNA_TORQUE_EN defined, SW=0001 -> first packet FF FF 01 04 03 18 01 DE; next packet is goal position 0x0000.
